// File: rtl/spring_node.sv
// rtl/spring_node.sv - position-Verlet mass-spring particle with N_NBR neighbour slots
// One start/done handshaked integration step: per-slot force accumulation, Verlet update, wall bounce.
module spring_node #(
    parameter int W          = 16,
    parameter int FRAC       = 4,
    parameter int N_NBR      = 3,
    parameter int MASS_SHIFT = 0,
    parameter int INIT_X     = 128,
    parameter int INIT_Y     = 128,
    parameter int REST       = 64,
    parameter int SPRING     = 8,
    parameter int DAMPING    = 4,
    parameter int POS_MAX    = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W-1:0]       ext_fx,
    input  logic [W-1:0]       ext_fy,
    input  logic [N_NBR*W-1:0] nbr_x,
    input  logic [N_NBR*W-1:0] nbr_y,
    input  logic [N_NBR*W-1:0] nbr_vx,
    input  logic [N_NBR*W-1:0] nbr_vy,
    input  logic [N_NBR-1:0]   nbr_en,
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       x,
    output logic [W-1:0]       y,
    output logic [W-1:0]       vel_x,
    output logic [W-1:0]       vel_y
);
    localparam int W2 = 2 * W;
    localparam int KW = (N_NBR > 1) ? $clog2(N_NBR) : 1;
    localparam logic signed [W2-1:0] SAT_HI   = W2'((1 << (W - 1)) - 1);
    localparam logic signed [W2-1:0] SAT_LO   = ~SAT_HI;
    localparam logic signed [W2-1:0] REST_W   = W2'(REST);
    localparam logic signed [W2-1:0] SPRING_W = W2'(SPRING);
    localparam logic signed [W2-1:0] DAMP_W   = W2'(DAMPING);
    localparam logic signed [W2-1:0] PMAX_W   = W2'(POS_MAX);

    typedef enum logic [2:0] {S_IDLE, S_NBR, S_INTEG, S_BOUND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [N_NBR-1:0]   en_q, en_d;
    logic [N_NBR*W-1:0] nx_q, nx_d, ny_q, ny_d, nvx_q, nvx_d, nvy_q, nvy_d;
    logic [W-1:0]       fx_q, fx_d, fy_q, fy_d;
    logic [W-1:0]       x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d, xo_q, xo_d, yo_q, yo_d;
    logic [W2-1:0]      xn_q, xn_d, yn_q, yn_d, vnx_q, vnx_d, vny_q, vny_d;

    function automatic logic signed [W2-1:0] sx(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [W2-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[W-1:0];
        else
            return v[W-1:0];
    endfunction

    // Wall bounce halves and reflects velocity; x_old is rebuilt so the next step carries it.
    function automatic void bound_axis(input logic signed [W2-1:0] pn, input logic signed [W2-1:0] vn,
                                       output logic [W-1:0] p, output logic [W-1:0] v,
                                       output logic [W-1:0] po);
        logic signed [W2-1:0] pb;
        logic signed [W2-1:0] vb;
        if (pn[W2-1]) begin
            pb = '0;
            vb = -(vn >>> 1);
        end else if (pn > PMAX_W) begin
            pb = PMAX_W;
            vb = -(vn >>> 1);
        end else begin
            pb = pn;
            vb = vn;
        end
        p  = sat(pb);
        v  = sat(vb);
        po = sat(sx(p) - sx(v));
    endfunction

    logic [W-1:0]         nx_k, ny_k, nvx_k, nvy_k;
    logic signed [W2-1:0] dx, dy, adx, ady, sp, fs, fsx, fsy, pvx, pvy, accx, accy;
    int                   kb;

    always_comb begin
        kb    = int'(k_q) * W;
        nx_k  = nx_q[kb +: W];
        ny_k  = ny_q[kb +: W];
        nvx_k = nvx_q[kb +: W];
        nvy_k = nvy_q[kb +: W];
        dx    = sx(x_q) - sx(nx_k);
        dy    = sx(y_q) - sx(ny_k);
        adx   = dx[W2-1] ? -dx : dx;
        ady   = dy[W2-1] ? -dy : dy;
        sp    = SPRING_W * (adx + ady - REST_W);
        fs    = sp >>> FRAC;
        if (dx == '0)
            fsx = '0;
        else
            fsx = dx[W2-1] ? -fs : fs;
        if (dy == '0)
            fsy = '0;
        else
            fsy = dy[W2-1] ? -fs : fs;
        pvx  = DAMP_W * (sx(vx_q) - sx(nvx_k));
        pvy  = DAMP_W * (sx(vy_q) - sx(nvy_k));
        accx = sx(fx_q) - (fsx + (pvx >>> FRAC));
        accy = sx(fy_q) - (fsy + (pvy >>> FRAC));
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        en_d    = en_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        nvx_d   = nvx_q;
        nvy_d   = nvy_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        xn_d    = xn_q;
        yn_d    = yn_q;
        vnx_d   = vnx_q;
        vny_d   = vny_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    en_d    = nbr_en;
                    nx_d    = nbr_x;
                    ny_d    = nbr_y;
                    nvx_d   = nbr_vx;
                    nvy_d   = nbr_vy;
                    fx_d    = ext_fx;
                    fy_d    = ext_fy;
                    k_d     = '0;
                    state_d = S_NBR;
                end
            end
            S_NBR: begin
                if (en_q[k_q]) begin
                    fx_d = sat(accx);
                    fy_d = sat(accy);
                end
                k_d = k_q + KW'(1);
                if (k_q == KW'(N_NBR - 1))
                    state_d = S_INTEG;
            end
            S_INTEG: begin
                xn_d    = sx(x_q) + sx(x_q) - sx(xo_q) + (sx(fx_q) >>> MASS_SHIFT);
                yn_d    = sx(y_q) + sx(y_q) - sx(yo_q) + (sx(fy_q) >>> MASS_SHIFT);
                vnx_d   = xn_d - sx(x_q);
                vny_d   = yn_d - sx(y_q);
                state_d = S_BOUND;
            end
            S_BOUND: begin
                bound_axis(xn_q, vnx_q, x_d, vx_d, xo_d);
                bound_axis(yn_q, vny_q, y_d, vy_d, yo_d);
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            en_q    <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            nvx_q   <= '0;
            nvy_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            x_q     <= W'(INIT_X);
            y_q     <= W'(INIT_Y);
            xo_q    <= W'(INIT_X);
            yo_q    <= W'(INIT_Y);
            vx_q    <= '0;
            vy_q    <= '0;
            xn_q    <= '0;
            yn_q    <= '0;
            vnx_q   <= '0;
            vny_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            en_q    <= en_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            nvx_q   <= nvx_d;
            nvy_q   <= nvy_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            xn_q    <= xn_d;
            yn_q    <= yn_d;
            vnx_q   <= vnx_d;
            vny_q   <= vny_d;
        end
    end

    assign busy  = (state_q == S_NBR) || (state_q == S_INTEG) || (state_q == S_BOUND);
    assign done  = (state_q == S_DONE);
    assign x     = x_q;
    assign y     = y_q;
    assign vel_x = vx_q;
    assign vel_y = vy_q;
endmodule

// File: tb/tb_spring_node.sv
// tb/tb_spring_node.sv - randomized bench for spring_node against an arithmetic step model
// Three instances: defaults (a), INIT_X=236 (b, shares a's inputs), W=12/N_NBR=8 (c).
module tb_spring_node;
    localparam int REST = 64, SPRING = 8, DAMPING = 4, FRAC = 4, MASS_SHIFT = 0, POS_MAX = 240;

    logic clk;
    logic reset, start_p, start_c;

    int          s_efx, s_efy;
    int          s_nx[8], s_ny[8], s_nvx[8], s_nvy[8];
    logic [7:0]  s_en;

    logic [15:0] p_efx, p_efy;
    logic [47:0] p_nx, p_ny, p_nvx, p_nvy;
    logic [2:0]  p_en;
    logic [11:0] c_efx, c_efy;
    logic [95:0] c_nx, c_ny, c_nvx, c_nvy;
    logic [7:0]  c_en;

    logic               a_busy, a_done, b_busy, b_done, c_busy, c_done;
    logic signed [15:0] a_x, a_y, a_vx, a_vy, b_x, b_y, b_vx, b_vy;
    logic signed [11:0] c_x, c_y, c_vx, c_vy;

    int   o_x[3], o_y[3], o_vx[3], o_vy[3];
    logic o_busy[3], o_done[3];

    int m_x[3], m_y[3], m_vx[3], m_vy[3], m_xo[3], m_yo[3];
    int n_checks = 0;
    int n_errors = 0;

    spring_node u_a (
        .clk(clk), .reset(reset), .start(start_p), .ext_fx(p_efx), .ext_fy(p_efy),
        .nbr_x(p_nx), .nbr_y(p_ny), .nbr_vx(p_nvx), .nbr_vy(p_nvy), .nbr_en(p_en),
        .busy(a_busy), .done(a_done), .x(a_x), .y(a_y), .vel_x(a_vx), .vel_y(a_vy)
    );

    spring_node #(.INIT_X(236)) u_b (
        .clk(clk), .reset(reset), .start(start_p), .ext_fx(p_efx), .ext_fy(p_efy),
        .nbr_x(p_nx), .nbr_y(p_ny), .nbr_vx(p_nvx), .nbr_vy(p_nvy), .nbr_en(p_en),
        .busy(b_busy), .done(b_done), .x(b_x), .y(b_y), .vel_x(b_vx), .vel_y(b_vy)
    );

    spring_node #(.W(12), .N_NBR(8)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .ext_fx(c_efx), .ext_fy(c_efy),
        .nbr_x(c_nx), .nbr_y(c_ny), .nbr_vx(c_nvx), .nbr_vy(c_nvy), .nbr_en(c_en),
        .busy(c_busy), .done(c_done), .x(c_x), .y(c_y), .vel_x(c_vx), .vel_y(c_vy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        p_efx = s_efx[15:0];
        p_efy = s_efy[15:0];
        c_efx = s_efx[11:0];
        c_efy = s_efy[11:0];
        p_en  = s_en[2:0];
        c_en  = s_en;
        p_nx = '0; p_ny = '0; p_nvx = '0; p_nvy = '0;
        c_nx = '0; c_ny = '0; c_nvx = '0; c_nvy = '0;
        for (int i = 0; i < 3; i++) begin
            p_nx[i*16 +: 16]  = s_nx[i][15:0];
            p_ny[i*16 +: 16]  = s_ny[i][15:0];
            p_nvx[i*16 +: 16] = s_nvx[i][15:0];
            p_nvy[i*16 +: 16] = s_nvy[i][15:0];
        end
        for (int i = 0; i < 8; i++) begin
            c_nx[i*12 +: 12]  = s_nx[i][11:0];
            c_ny[i*12 +: 12]  = s_ny[i][11:0];
            c_nvx[i*12 +: 12] = s_nvx[i][11:0];
            c_nvy[i*12 +: 12] = s_nvy[i][11:0];
        end
    end

    always_comb begin
        o_x[0] = int'(a_x); o_y[0] = int'(a_y); o_vx[0] = int'(a_vx); o_vy[0] = int'(a_vy);
        o_x[1] = int'(b_x); o_y[1] = int'(b_y); o_vx[1] = int'(b_vx); o_vy[1] = int'(b_vy);
        o_x[2] = int'(c_x); o_y[2] = int'(c_y); o_vx[2] = int'(c_vx); o_vy[2] = int'(c_vy);
        o_busy[0] = a_busy; o_busy[1] = b_busy; o_busy[2] = c_busy;
        o_done[0] = a_done; o_done[1] = b_done; o_done[2] = c_done;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pw(input int id);
        return (id == 2) ? 12 : 16;
    endfunction

    function automatic int pn(input int id);
        return (id == 2) ? 8 : 3;
    endfunction

    function automatic int sat(input int v, input int w);
        int hi;
        hi = (1 << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 3; id++) begin
            m_x[id] = (id == 1) ? 236 : 128;
            m_xo[id] = m_x[id];
            m_y[id] = 128;
            m_yo[id] = 128;
            m_vx[id] = 0;
            m_vy[id] = 0;
        end
    endtask

    task automatic model_axis(input int w, input int f, inout int p, inout int po, output int v);
        int pnx, vn;
        pnx = 2 * p - po + (f >>> MASS_SHIFT);
        vn  = pnx - p;
        if (pnx < 0) begin
            p = 0;
            v = sat(-(vn >>> 1), w);
        end else if (pnx > POS_MAX) begin
            p = POS_MAX;
            v = sat(-(vn >>> 1), w);
        end else begin
            p = sat(pnx, w);
            v = sat(vn, w);
        end
        po = sat(p - v, w);
    endtask

    task automatic model_step(input int id);
        int w, fx, fy, dx, dy, fs;
        w  = pw(id);
        fx = s_efx;
        fy = s_efy;
        for (int k = 0; k < pn(id); k++) begin
            if (s_en[k]) begin
                dx = m_x[id] - s_nx[k];
                dy = m_y[id] - s_ny[k];
                fs = (SPRING * (iabs(dx) + iabs(dy) - REST)) >>> FRAC;
                fx = sat(fx - (fs * sgn(dx) + ((DAMPING * (m_vx[id] - s_nvx[k])) >>> FRAC)), w);
                fy = sat(fy - (fs * sgn(dy) + ((DAMPING * (m_vy[id] - s_nvy[k])) >>> FRAC)), w);
            end
        end
        model_axis(w, fx, m_x[id], m_xo[id], m_vx[id]);
        model_axis(w, fy, m_y[id], m_yo[id], m_vy[id]);
    endtask

    task automatic check_out(input int id, input string tag);
        check($sformatf("%s.x%0d", tag, id), o_x[id], m_x[id]);
        check($sformatf("%s.y%0d", tag, id), o_y[id], m_y[id]);
        check($sformatf("%s.vx%0d", tag, id), o_vx[id], m_vx[id]);
        check($sformatf("%s.vy%0d", tag, id), o_vy[id], m_vy[id]);
    endtask

    task automatic clear_inputs();
        s_efx = 0;
        s_efy = 0;
        s_en  = '0;
        for (int i = 0; i < 8; i++) begin
            s_nx[i] = 0; s_ny[i] = 0; s_nvx[i] = 0; s_nvy[i] = 0;
        end
    endtask

    task automatic rand_inputs();
        s_efx = int'($urandom_range(0, 127)) - 64;
        s_efy = int'($urandom_range(0, 127)) - 64;
        for (int i = 0; i < 8; i++) begin
            s_nx[i]  = int'($urandom_range(0, 255));
            s_ny[i]  = int'($urandom_range(0, 255));
            s_nvx[i] = int'($urandom_range(0, 63)) - 32;
            s_nvy[i] = int'($urandom_range(0, 63)) - 32;
        end
        s_en = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // grp 0 steps instances a and b together, grp 1 steps instance c.
    task automatic run_step(input int grp, input string tag);
        int n, lo, hi, cyc;
        n  = (grp == 0) ? 3 : 8;
        lo = (grp == 0) ? 0 : 2;
        hi = (grp == 0) ? 1 : 2;
        @(negedge clk);
        if (grp == 0) start_p = 1'b1;
        else          start_c = 1'b1;
        for (int id = lo; id <= hi; id++) model_step(id);
        @(negedge clk);
        start_p = 1'b0;
        start_c = 1'b0;
        check({tag, ".busy"}, int'(o_busy[lo]), 1);
        rand_inputs();
        cyc = 0;
        while (o_done[lo] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".done_edge"}, cyc, n + 2);
        check({tag, ".busy_end"}, int'(o_busy[lo]), 0);
        for (int id = lo; id <= hi; id++) check_out(id, tag);
        @(negedge clk);
        check({tag, ".done_once"}, int'(o_done[lo]), 0);
    endtask

    initial begin
        int dcnt, first;
        reset   = 1'b1;
        start_p = 1'b0;
        start_c = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int id = 0; id < 3; id++) begin
            check($sformatf("rst.busy%0d", id), int'(o_busy[id]), 0);
            check($sformatf("rst.done%0d", id), int'(o_done[id]), 0);
            check_out(id, "rst");
        end

        clear_inputs();
        s_en = 8'b001; s_nx[0] = 192; s_ny[0] = 128;
        run_step(0, "equil");
        check("equil.const_x", o_x[0], 128);
        check("equil.const_vx", o_vx[0], 0);

        do_reset();
        clear_inputs();
        s_en = 8'b001; s_nx[0] = 208; s_ny[0] = 128;
        run_step(0, "stretch1");
        check("stretch1.const_x", o_x[0], 136);
        check("stretch1.const_vx", o_vx[0], 8);
        check("stretch1.const_y", o_y[0], 128);
        clear_inputs();
        s_en = 8'b001; s_nx[0] = 208; s_ny[0] = 128;
        run_step(0, "stretch2");

        do_reset();
        clear_inputs();
        s_efx = 16;
        run_step(0, "bounce1");
        check("bounce1.const_x", o_x[1], 240);
        check("bounce1.const_vx", o_vx[1], -8);
        clear_inputs();
        run_step(0, "bounce2");
        check("bounce2.const_x", o_x[1], 232);

        // start held high through busy and the done cycle must yield exactly one step
        clear_inputs();
        s_en = 8'b011; s_nx[0] = 200; s_ny[0] = 100; s_nx[1] = 60; s_ny[1] = 150; s_efx = 5;
        @(negedge clk);
        start_p = 1'b1;
        model_step(0);
        model_step(1);
        dcnt  = 0;
        first = -1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (cyc == 1) rand_inputs();
            if (cyc == 7) start_p = 1'b0;
            if (o_done[0] === 1'b1) begin
                dcnt++;
                if (first < 0) first = cyc;
            end
        end
        check("hs.done_count", dcnt, 1);
        check("hs.done_cycle", first, 6);
        check("hs.busy_end", int'(o_busy[0]), 0);
        check_out(0, "hs");
        check_out(1, "hs");
        rand_inputs();
        run_step(0, "hs_again");

        rand_inputs();
        @(negedge clk);
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("mid_rst.busy", int'(o_busy[0]), 0);
        check("mid_rst.done", int'(o_done[0]), 0);
        check_out(0, "mid_rst");
        check_out(1, "mid_rst");
        reset = 1'b0;
        dcnt  = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done[0] === 1'b1) dcnt++;
        end
        check("mid_rst.no_done", dcnt, 0);
        rand_inputs();
        run_step(0, "post_rst");

        for (int i = 0; i < 30; i++) begin
            rand_inputs();
            run_step(0, $sformatf("rnd%0d", i));
        end

        do_reset();
        clear_inputs();
        s_en  = 8'hff;
        s_efx = 2047;
        run_step(1, "sat");
        check("sat.const_x", o_x[2], 240);
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            run_step(1, $sformatf("big%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
